// File: rtl/osd_vram_wr_queue_pkg.sv
// Shared types and helpers for the OSD VRAM write queue: FSM state encoding,
// default VRAM geometry and the log2 used to size the occupancy counter.
package osd_vram_wr_queue_pkg;

    localparam int C_AW_DEF = 10;
    localparam int C_DW_DEF = 8;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_FILL = 1'b1
    } state_t;

    // Ceiling log2; exact for the power-of-two depths this block accepts.
    function automatic int f_log2(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) r = i + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/osd_cmd_fifo.sv
// Synchronous show-ahead FIFO holding address/data write commands.
// The head entry is readable combinationally so a pop can feed the output registers directly.
module osd_cmd_fifo
    import osd_vram_wr_queue_pkg::*;
#(
    parameter int C_W     = C_AW_DEF + C_DW_DEF,
    parameter int C_DEPTH = 16,
    parameter int C_LW    = f_log2(C_DEPTH) + 1
) (
    input  logic            CK_i,
    input  logic            XSYS_R_i,
    input  logic            PUSH_i,
    input  logic [C_W-1:0]  WD_i,
    input  logic            POP_i,
    output logic [C_W-1:0]  RD_o,
    output logic            FULL_o,
    output logic            EMPTY_o,
    output logic [C_LW-1:0] LEVEL_o
);

    localparam int C_PW = f_log2(C_DEPTH);

    logic [C_W-1:0]  r_mem [C_DEPTH];
    logic [C_PW-1:0] r_wr_ptr;
    logic [C_PW-1:0] r_rd_ptr;
    logic [C_LW-1:0] r_level;
    logic            w_full;
    logic            w_empty;
    logic            w_wr;
    logic            w_rd;

    assign w_full  = (r_level == C_LW'(C_DEPTH));
    assign w_empty = (r_level == '0);
    assign w_rd    = POP_i & ~w_empty;
    // When full, a simultaneous pop frees the slot the write lands in.
    assign w_wr    = PUSH_i & (~w_full | w_rd);

    always_ff @(posedge CK_i) begin
        if (w_wr) r_mem[r_wr_ptr] <= WD_i;
    end

    always_ff @(posedge CK_i or negedge XSYS_R_i) begin
        if (!XSYS_R_i) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_wr) r_wr_ptr <= r_wr_ptr + C_PW'(1);
            if (w_rd) r_rd_ptr <= r_rd_ptr + C_PW'(1);
            r_level <= r_level + C_LW'(w_wr) - C_LW'(w_rd);
        end
    end

    assign RD_o    = r_mem[r_rd_ptr];
    assign FULL_o  = w_full;
    assign EMPTY_o = w_empty;
    assign LEVEL_o = r_level;

endmodule

// File: rtl/osd_vram_wr_queue.sv
// CPU-to-VRAM write queue: toggle-strobed commands are queued and drained into
// the character VRAM during blanking; also performs a hardware full-screen fill.
//   state   | meaning
//   ST_IDLE | drain FIFO entries while the gate is open; wait for fill request
//   ST_FILL | write FVAL to every VRAM cell in order; FIFO pops suspended
module osd_vram_wr_queue
    import osd_vram_wr_queue_pkg::*;
#(
    parameter int C_AW         = C_AW_DEF,
    parameter int C_DW         = C_DW_DEF,
    parameter int C_DEPTH      = 16,
    parameter int C_BLANK_GATE = 1
) (
    input  logic                       CK_i,
    input  logic                       XSYS_R_i,
    input  logic [C_AW-1:0]            CMD_WAs_i,
    input  logic [C_DW-1:0]            CMD_WDs_i,
    input  logic                       CMD_AINC_i,
    input  logic                       CMD_STB_i,
    input  logic                       FILL_REQ_i,
    input  logic                       OVF_CLR_i,
    input  logic                       BLANK_i,
    output logic [C_AW-1:0]            VRAM_WAs_o,
    output logic [C_DW-1:0]            VRAM_WDs_o,
    output logic                       VRAM_WE_o,
    output logic [f_log2(C_DEPTH):0]   STS_LEVELs_o,
    output logic                       STS_OVF_o,
    output logic                       STS_BUSY_o
);

    localparam int C_LW = f_log2(C_DEPTH) + 1;
    localparam int C_W  = C_AW + C_DW;

    logic            r_stb_d;
    logic            r_fill_d;
    logic [C_AW-1:0] r_ptr;
    logic [C_AW-1:0] r_fcnt;
    logic [C_DW-1:0] r_fval;
    state_t          r_state;
    state_t          w_state_nxt;
    logic            r_we;
    logic [C_AW-1:0] r_wa;
    logic [C_DW-1:0] r_wd;
    logic            r_ovf;
    logic            r_busy;

    logic            w_push;
    logic            w_fill_req;
    logic            w_gate;
    logic            w_pop;
    logic            w_fill_wr;
    logic            w_accept;
    logic            w_drop;
    logic [C_AW-1:0] w_entry_wa;
    logic [C_W-1:0]  w_head;
    logic            w_full;
    logic            w_empty;
    logic [C_LW-1:0] w_level;
    logic [C_LW-1:0] w_level_nxt;

    assign w_push      = CMD_STB_i ^ r_stb_d;
    assign w_fill_req  = FILL_REQ_i & ~r_fill_d;
    assign w_gate      = (C_BLANK_GATE == 0) ? 1'b1 : BLANK_i;
    assign w_entry_wa  = CMD_AINC_i ? r_ptr : CMD_WAs_i;
    assign w_accept    = w_push & (~w_full | w_pop);
    assign w_drop      = w_push & w_full & ~w_pop;
    assign w_level_nxt = w_level + C_LW'(w_accept) - C_LW'(w_pop);

    osd_cmd_fifo #(
        .C_W     (C_W),
        .C_DEPTH (C_DEPTH),
        .C_LW    (C_LW)
    ) u_fifo (
        .CK_i     (CK_i),
        .XSYS_R_i (XSYS_R_i),
        .PUSH_i   (w_push),
        .WD_i     ({w_entry_wa, CMD_WDs_i}),
        .POP_i    (w_pop),
        .RD_o     (w_head),
        .FULL_o   (w_full),
        .EMPTY_o  (w_empty),
        .LEVEL_o  (w_level)
    );

    always_comb begin
        w_state_nxt = r_state;
        w_pop       = 1'b0;
        w_fill_wr   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_pop = ~w_empty & w_gate;
                if (w_fill_req) w_state_nxt = ST_FILL;
            end
            ST_FILL: begin
                w_fill_wr = w_gate;
                if (w_gate && (r_fcnt == '1)) w_state_nxt = ST_IDLE;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge CK_i or negedge XSYS_R_i) begin
        if (!XSYS_R_i) begin
            r_state  <= ST_IDLE;
            r_stb_d  <= 1'b0;
            r_fill_d <= 1'b0;
            r_ptr    <= '0;
            r_fcnt   <= '0;
            r_fval   <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_stb_d  <= CMD_STB_i;
            r_fill_d <= FILL_REQ_i;
            if (w_accept) r_ptr <= w_entry_wa + C_AW'(1);
            if ((r_state == ST_IDLE) && w_fill_req) begin
                r_fcnt <= '0;
                r_fval <= CMD_WDs_i;
            end else if (w_fill_wr) begin
                r_fcnt <= r_fcnt + C_AW'(1);
            end
        end
    end

    always_ff @(posedge CK_i or negedge XSYS_R_i) begin
        if (!XSYS_R_i) begin
            r_we   <= 1'b0;
            r_wa   <= '0;
            r_wd   <= '0;
            r_ovf  <= 1'b0;
            r_busy <= 1'b0;
        end else begin
            r_we <= w_pop | w_fill_wr;
            if (w_pop) begin
                {r_wa, r_wd} <= w_head;
            end else if (w_fill_wr) begin
                r_wa <= r_fcnt;
                r_wd <= r_fval;
            end
            // A drop in the same cycle as a clear keeps the flag set.
            if (w_drop)         r_ovf <= 1'b1;
            else if (OVF_CLR_i) r_ovf <= 1'b0;
            r_busy <= (w_level_nxt != '0) | (w_state_nxt == ST_FILL);
        end
    end

    assign VRAM_WE_o    = r_we;
    assign VRAM_WAs_o   = r_wa;
    assign VRAM_WDs_o   = r_wd;
    assign STS_LEVELs_o = w_level;
    assign STS_OVF_o    = r_ovf;
    assign STS_BUSY_o   = r_busy;

endmodule

// File: tb/tb_osd_vram_wr_queue.sv
// Directed bench for osd_vram_wr_queue: expected VRAM writes are queued on the
// scoreboard as stimulus is driven and matched by a monitor as writes appear.
module tb_osd_vram_wr_queue;

    logic        clk;
    logic        rst_n;
    logic [9:0]  cmd_wa;
    logic [7:0]  cmd_wd;
    logic        cmd_ainc;
    logic        cmd_stb;
    logic        fill_req;
    logic        ovf_clr;
    logic        blank;
    logic [9:0]  vram_wa;
    logic [7:0]  vram_wd;
    logic        vram_we;
    logic [4:0]  sts_level;
    logic        sts_ovf;
    logic        sts_busy;

    int          checks = 0;
    int          errors = 0;
    int          wr_cnt = 0;
    logic        blank_s = 1'b0;
    logic [17:0] sb [$];

    osd_vram_wr_queue dut (
        .CK_i         (clk),
        .XSYS_R_i     (rst_n),
        .CMD_WAs_i    (cmd_wa),
        .CMD_WDs_i    (cmd_wd),
        .CMD_AINC_i   (cmd_ainc),
        .CMD_STB_i    (cmd_stb),
        .FILL_REQ_i   (fill_req),
        .OVF_CLR_i    (ovf_clr),
        .BLANK_i      (blank),
        .VRAM_WAs_o   (vram_wa),
        .VRAM_WDs_o   (vram_wd),
        .VRAM_WE_o    (vram_we),
        .STS_LEVELs_o (sts_level),
        .STS_OVF_o    (sts_ovf),
        .STS_BUSY_o   (sts_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Issues one command: toggles the strobe and advances to the next falling edge.
    task automatic cmd(input logic [9:0] wa, input logic [7:0] wd, input logic ainc);
        cmd_wa   = wa;
        cmd_wd   = wd;
        cmd_ainc = ainc;
        cmd_stb  = ~cmd_stb;
        @(negedge clk);
    endtask

    task automatic drain(input string tag, input int budget);
        for (int c = 0; c < budget && sb.size() != 0; c++) @(negedge clk);
        check(tag, sb.size(), 0);
    endtask

    always begin
        @(posedge clk);
        blank_s = blank;
        #2;
        if (vram_we === 1'b1) begin
            logic [17:0] e;
            wr_cnt++;
            check("we_while_blank", blank_s, 1'b1);
            check("sb_nonempty", sb.size() != 0, 1'b1);
            if (sb.size() != 0) begin
                e = sb.pop_front();
                check("vram_entry", {vram_wa, vram_wd}, e);
            end
        end
    end

    initial begin
        int n0;
        rst_n = 1'b0; cmd_wa = '0; cmd_wd = '0; cmd_ainc = 1'b0; cmd_stb = 1'b0;
        fill_req = 1'b0; ovf_clr = 1'b0; blank = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_we", vram_we, 0);
        check("rst_wa", vram_wa, 0);
        check("rst_wd", vram_wd, 0);
        check("rst_level", sts_level, 0);
        check("rst_ovf", sts_ovf, 0);
        check("rst_busy", sts_busy, 0);
        rst_n = 1'b1;
        @(negedge clk);

        // Basic drain and latency
        blank = 1'b1;
        sb.push_back({10'h005, 8'h41});
        cmd(10'h005, 8'h41, 1'b0);
        check("basic_level1", sts_level, 1);
        check("basic_we_early", vram_we, 0);
        check("basic_busy", sts_busy, 1);
        @(negedge clk);
        check("basic_we", vram_we, 1);
        check("basic_wa", vram_wa, 10'h005);
        check("basic_wd", vram_wd, 8'h41);
        check("basic_level0", sts_level, 0);
        @(negedge clk);
        check("basic_we_pulse", vram_we, 0);

        // Auto-increment with address wrap
        sb.push_back({10'h3FE, 8'h10});
        sb.push_back({10'h3FF, 8'h11});
        sb.push_back({10'h000, 8'h12});
        sb.push_back({10'h001, 8'h13});
        cmd(10'h3FE, 8'h10, 1'b0);
        cmd(10'h155, 8'h11, 1'b1);
        cmd(10'h155, 8'h12, 1'b1);
        cmd(10'h155, 8'h13, 1'b1);
        drain("ainc_drain", 20);

        // Blank gating
        blank = 1'b0;
        n0 = wr_cnt;
        for (int i = 0; i < 4; i++) begin
            sb.push_back({10'h100 + 10'(i), 8'h50 + 8'(i)});
            cmd(10'h100 + 10'(i), 8'h50 + 8'(i), 1'b0);
        end
        repeat (3) @(negedge clk);
        check("gate_level4", sts_level, 4);
        check("gate_nowrite", wr_cnt - n0, 0);
        blank = 1'b1;
        repeat (2) @(negedge clk);
        blank = 1'b0;
        repeat (3) @(negedge clk);
        check("gate_two_writes", wr_cnt - n0, 2);
        check("gate_level2", sts_level, 2);
        blank = 1'b1;
        drain("gate_drain", 20);
        check("gate_busy_off", sts_busy, 0);

        // Overflow, clear/set priority, push+pop while full
        blank = 1'b0;
        for (int i = 0; i < 17; i++) begin
            if (i < 16) sb.push_back({10'h200 + 10'(i), 8'h80 + 8'(i)});
            cmd(10'h200 + 10'(i), 8'h80 + 8'(i), 1'b0);
        end
        check("ovf_level16", sts_level, 16);
        check("ovf_flag", sts_ovf, 1);
        ovf_clr = 1'b1;
        cmd(10'h230, 8'hEE, 1'b0);
        ovf_clr = 1'b0;
        check("ovf_set_wins", sts_ovf, 1);
        ovf_clr = 1'b1;
        @(negedge clk);
        ovf_clr = 1'b0;
        check("ovf_cleared", sts_ovf, 0);
        blank = 1'b1;
        sb.push_back({10'h2FF, 8'hA5});
        cmd(10'h2FF, 8'hA5, 1'b0);
        check("full_pushpop_level", sts_level, 16);
        check("full_pushpop_noovf", sts_ovf, 0);
        drain("ovf_drain", 40);
        check("ovf_level0", sts_level, 0);
        check("ovf_busy_off", sts_busy, 0);

        // Fill with toggling blank, pushes held until the fill completes
        n0 = wr_cnt;
        cmd_wd = 8'h20;
        fill_req = 1'b1;
        for (int a = 0; a < 1024; a++) sb.push_back({10'(a), 8'h20});
        for (int c = 0; c < 3000 && sb.size() != 0; c++) begin
            @(negedge clk);
            blank = (c % 4) != 3;
            if (c == 20) begin
                sb.push_back({10'h0AA, 8'h77});
                cmd_wa = 10'h0AA; cmd_wd = 8'h77; cmd_ainc = 1'b0; cmd_stb = ~cmd_stb;
            end
            if (c == 21) begin
                sb.push_back({10'h0AB, 8'h78});
                cmd_wa = 10'h0AB; cmd_wd = 8'h78; cmd_stb = ~cmd_stb;
            end
            if (c == 30) begin
                check("fill_held_level", sts_level, 2);
                check("fill_busy", sts_busy, 1);
            end
            if (c == 40) fill_req = 1'b0;
            if (c == 41) fill_req = 1'b1;
        end
        check("fill_drain", sb.size(), 0);
        check("fill_write_count", wr_cnt - n0, 1026);
        check("fill_busy_off", sts_busy, 0);
        check("fill_level0", sts_level, 0);

        // Reset in the middle of a fill
        blank = 1'b1;
        fill_req = 1'b0;
        @(negedge clk);
        cmd_wd = 8'h33;
        fill_req = 1'b1;
        for (int a = 0; a < 300; a++) sb.push_back({10'(a), 8'h33});
        drain("fill300_drain", 1000);
        rst_n = 1'b0;
        fill_req = 1'b0;
        #1;
        check("mid_rst_we", vram_we, 0);
        check("mid_rst_wa", vram_wa, 0);
        check("mid_rst_wd", vram_wd, 0);
        check("mid_rst_level", sts_level, 0);
        check("mid_rst_ovf", sts_ovf, 0);
        check("mid_rst_busy", sts_busy, 0);
        n0 = wr_cnt;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        check("post_rst_nowrite", wr_cnt - n0, 0);
        check("post_rst_busy", sts_busy, 0);
        cmd_wd = 8'h44;
        fill_req = 1'b1;
        for (int a = 0; a < 1024; a++) sb.push_back({10'(a), 8'h44});
        drain("refill_drain", 2000);
        check("refill_count", wr_cnt - n0, 1024);
        check("refill_busy_off", sts_busy, 0);

        repeat (3) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
